// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Decode-side producer of the pipeline destination-register stream. Keeps a
// three-deep shadow of the instructions in EX, MEM and WB ({valid, dest,
// is_load}), publishes their destinations to the forwarding unit, and raises
// the pipeline control signals:
//   stall  - load-use hazard: hold PC and IF/ID, inject a bubble into EX
//   flush  - taken branch in EX: squash the IF/ID instruction
//   freeze - data memory busy: every pipeline register holds
//
// Priority: RST > mem_busy > ex_branch_taken > load-use.
//
// Ports:
//   CLK, RST          clock; synchronous active-high reset
//   id_valid          decode stage holds a real instruction
//   id_rs, id_rt      decode source registers
//   id_wsel           decode destination register (0 = no write)
//   id_is_load        decode instruction is a load
//   ex_branch_taken   branch in EX resolved taken
//   mem_busy          data memory not ready
//   write1/2/3        EX/MEM/WB destination (0 when the entry is invalid)
//   stall/flush/freeze pipeline control outputs
//
// Optional build macro HAZARD_STATS_EN adds saturating 32-bit event counters
// stall_cnt, flush_cnt and freeze_cnt (cycles with the output at 1).
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_wsel,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic [REG_W-1:0] write1,
  output logic [REG_W-1:0] write2,
  output logic [REG_W-1:0] write3,
  output logic             stall,
  output logic             flush,
  output logic             freeze
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt,
  output logic [31:0]      freeze_cnt
`endif
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             is_load;
  } entry_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FREEZE  = 2'd1,
    LDSTALL = 2'd2
  } state_t;

  localparam entry_t BUBBLE = '{valid: 1'b0, dest: '0, is_load: 1'b0};

  entry_t ex_q, mem_q, wb_q;
  state_t state_q, state_d;
  logic   load_use;

  // Hazard against the load currently in EX. A load into $zero never
  // produces a value, so it cannot be a producer.
  assign load_use = id_valid && ex_q.valid && ex_q.is_load &&
                    (ex_q.dest != '0) &&
                    ((ex_q.dest == id_rs) || (ex_q.dest == id_rt));

  // Control outputs. The LDSTALL gate is redundant with the bubble that a
  // stall places in EX, but makes the single-cycle stall explicit.
  assign freeze = !RST && mem_busy;
  assign flush  = !RST && !mem_busy && ex_branch_taken;
  assign stall  = !RST && !mem_busy && !ex_branch_taken && load_use &&
                  (state_q != LDSTALL);

  // Destinations come straight from the entry flops; reset forces them to 0
  // in the reset cycle itself.
  assign write1 = (!RST && ex_q.valid)  ? ex_q.dest  : '0;
  assign write2 = (!RST && mem_q.valid) ? mem_q.dest : '0;
  assign write3 = (!RST && wb_q.valid)  ? wb_q.dest  : '0;

  // Next-state logic.
  // NOTE: state_d gets a default before any branch so no path leaves it
  // unassigned; otherwise a latch would be inferred.
  always_comb begin
    state_d = RUN;
    if (mem_busy)   state_d = FREEZE;
    else if (stall) state_d = LDSTALL;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, which is what makes the shift WB<=MEM<=EX
  // correct regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_q    <= BUBBLE;
    end else begin
      state_q <= state_d;
      if (!mem_busy) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        if (stall || ex_branch_taken || !id_valid)
          ex_q <= BUBBLE;
        else
          ex_q <= '{valid: 1'b1, dest: id_wsel, is_load: id_is_load};
      end
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating event counters; each counts cycles with its output high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall  && (stall_cnt  != 32'hFFFF_FFFF)) stall_cnt  <= stall_cnt  + 32'd1;
      if (flush  && (flush_cnt  != 32'hFFFF_FFFF)) flush_cnt  <= flush_cnt  + 32'd1;
      if (freeze && (freeze_cnt != 32'hFFFF_FFFF)) freeze_cnt <= freeze_cnt + 32'd1;
    end
  end
`endif

endmodule
